// File: rtl/div_pkg.sv
// Shared divider codes and timing, imported by the divider and the ALU control.
package div_pkg;

    localparam logic [5:0] F_DIVU      = 6'b011011;
    localparam logic [5:0] F_MFHI      = 6'b010000;
    localparam logic [5:0] F_MFLO      = 6'b010010;
    localparam logic [5:0] F_HILO_OPEN = 6'b111111;

    // One restoring step per clock; the control's divu window is DIV_ITER + 1 clocks.
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/divu_hilo_if.sv
// Request/response bundle between the EX stage and the HI/LO divider.
interface divu_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic [5:0]       funct;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hilo_out;
    logic             busy;
    logic             done;

    modport master (
        output funct,
        output dividend,
        output divisor,
        input  hilo_out,
        input  busy,
        input  done
    );

    modport slave (
        input  funct,
        input  dividend,
        input  divisor,
        output hilo_out,
        output busy,
        output done
    );
endinterface

// File: rtl/divu_hilo_div_step.sv
// One restoring-division step: trial subtract of D from {R, Q msb}.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // R stays below D, so r_i[WIDTH] is always 0 and the wide subtract equals the
    // WIDTH+1-bit trial subtract; its top bit is the borrow.
    always_comb begin
        shifted = {r_i, q_msb_i};
        diff    = shifted - {2'b00, d_i};
        q_bit_o = ~diff[WIDTH+1];
        r_o     = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/divu_hilo.sv
// Multi-cycle unsigned divider with HI/LO pair; 32 steps plus one commit cycle.
module divu_hilo
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    divu_hilo_if.slave  bus
);

    div_state_t       state_q, state_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_r;
    logic             step_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[WIDTH-1]),
        .d_i     (d_q),
        .r_o     (step_r),
        .q_bit_o (step_bit)
    );

    // Next-state: arming, start capture, step datapath, commit, registered flags.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        // A held divu must drop for one edge before another start is accepted.
        if (bus.funct != F_DIVU) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.funct == F_DIVU && armed_q) begin
                    armed_d = 1'b0;
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hi_d    = r_q[WIDTH-1:0];
                lo_d    = q_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Read port into the result MUX; not gated by busy.
    always_comb begin
        bus.hilo_out = '0;
        if (bus.funct == F_MFHI) begin
            bus.hilo_out = hi_q;
        end else if (bus.funct == F_MFLO) begin
            bus.hilo_out = lo_q;
        end
        bus.busy = busy_q;
        bus.done = done_q;
    end

endmodule

// File: tb/tb_divu_hilo.sv
// Directed bench for divu_hilo: latency, results, divide-by-zero, reset, re-arm.
module tb_divu_hilo;
    import div_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   passes;

    divu_hilo_if #(.WIDTH(32)) bus ();

    divu_hilo #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Called at a negedge; reads LO then HI through the combinational port.
    task automatic read_hilo(output logic [31:0] lo, output logic [31:0] hi);
        bus.funct = F_MFLO;
        #1 lo = bus.hilo_out;
        bus.funct = F_MFHI;
        #1 hi = bus.hilo_out;
        bus.funct = 6'h00;
    endtask

    // Returns at the negedge after E0 with funct back at a no-op.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.funct    = F_DIVU;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.funct = 6'h00;
    endtask

    // Cycle c=1 is the cycle after E0; done belongs in c=33.
    task automatic wait_done(output int busy_cyc, output int done_at);
        busy_cyc = 0;
        done_at  = -1;
        for (int c = 1; c <= 100; c++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) done_at = (done_at == -1) ? c : -2;
            if (!bus.busy) break;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] lo, hi;
        int          bc, da, dones;
        total        = 0;
        passes       = 0;
        bus.funct    = 6'h00;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        read_hilo(lo, hi);
        check("reset_lo", lo, 32'd0);
        check("reset_hi", hi, 32'd0);
        rst_n = 1'b1;

        // 100 / 7
        start_div(32'd100, 32'd7);
        wait_done(bc, da);
        check("100_7_busy_cycles", 32'(bc), 32'd33);
        check("100_7_done_cycle", 32'(da), 32'd33);
        read_hilo(lo, hi);
        check("100_7_lo", lo, 32'd14);
        check("100_7_hi", hi, 32'd2);

        // Boundary operands
        start_div(32'hFFFF_FFFF, 32'd1);
        wait_done(bc, da);
        read_hilo(lo, hi);
        check("max_1_lo", lo, 32'hFFFF_FFFF);
        check("max_1_hi", hi, 32'd0);
        start_div(32'h8000_0000, 32'h8000_0001);
        wait_done(bc, da);
        read_hilo(lo, hi);
        check("msb_lo", lo, 32'd0);
        check("msb_hi", hi, 32'h8000_0000);

        // Divide by zero
        start_div(32'd5, 32'd0);
        wait_done(bc, da);
        check("div0_busy_cycles", 32'(bc), 32'd33);
        check("div0_done_cycle", 32'(da), 32'd33);
        read_hilo(lo, hi);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'd5);

        // Reset after E10 of 100/7
        start_div(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        read_hilo(lo, hi);
        check("midrst_lo", lo, 32'd0);
        check("midrst_hi", hi, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_div(32'd9, 32'd4);
        wait_done(bc, da);
        read_hilo(lo, hi);
        check("after_rst_lo", lo, 32'd2);
        check("after_rst_hi", hi, 32'd1);

        // funct held at divu for 80 cycles; operands change after start
        @(negedge clk);
        bus.funct    = F_DIVU;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bc    = 0;
        dones = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 5) begin
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end
            if (bus.busy) bc++;
            if (bus.done) dones++;
        end
        check("hold_busy_cycles", 32'(bc), 32'd33);
        check("hold_done_pulses", 32'(dones), 32'd1);
        read_hilo(lo, hi);
        check("hold_lo", lo, 32'd14);
        check("hold_hi", hi, 32'd2);

        // Old LO visible while busy, new one after commit
        start_div(32'd9, 32'd4);
        bus.funct = F_MFLO;
        #1 check("busy_read_lo", bus.hilo_out, 32'd14);
        bus.funct = 6'h00;
        wait_done(bc, da);
        check("second_busy_cycles", 32'(bc), 32'd33);
        read_hilo(lo, hi);
        check("second_lo", lo, 32'd2);
        check("second_hi", hi, 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
